// File: rtl/pkg_llc.sv
// Shared types and default geometry for the last-level-cache tag controller.
package pkg_llc;

    localparam int unsigned DefAddrSize  = 32;
    localparam int unsigned DefNWay      = 8;
    localparam int unsigned DefNumSets   = 1024;
    localparam int unsigned DefLineBytes = 64;

    typedef enum logic [1:0] {MesiI, MesiS, MesiE, MesiM} mesi_e;

    typedef enum logic [1:0] {OpRead, OpWrite, OpSnoopRd, OpSnoopInv} req_op_e;

    typedef enum logic [1:0] {StInit, StIdle, StLookup, StResp} llc_state_e;

    function automatic logic is_dirty(mesi_e m);
        return m == MesiM;
    endfunction

endpackage

// File: rtl/llc_tag_ctrl_if.sv
// Request/response handshake bundle between the front end and the LLC tag controller.
interface llc_tag_ctrl_if #(
    parameter int unsigned ADDR_SIZE = 32,
    parameter int unsigned N_WAY     = 8
);
    localparam int unsigned WAY_W = $clog2(N_WAY);

    logic                 req_valid;
    logic                 req_ready;
    logic [1:0]           req_op;
    logic [ADDR_SIZE-1:0] req_addr;
    logic                 req_shared;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic                 rsp_hit;
    logic [WAY_W-1:0]     rsp_way;
    logic [1:0]           rsp_mesi;
    logic                 rsp_wb;
    logic [ADDR_SIZE-1:0] rsp_wb_addr;
    logic                 init_done;

    modport slave (
        input  req_valid, req_op, req_addr, req_shared, rsp_ready,
        output req_ready, rsp_valid, rsp_hit, rsp_way, rsp_mesi, rsp_wb, rsp_wb_addr, init_done
    );

    modport master (
        output req_valid, req_op, req_addr, req_shared, rsp_ready,
        input  req_ready, rsp_valid, rsp_hit, rsp_way, rsp_mesi, rsp_wb, rsp_wb_addr, init_done
    );

endinterface

// File: rtl/llc_plru_tree.sv
// Tree-PLRU helper: victim walk and touch update over heap-indexed node bits (node 0 = root).
module llc_plru_tree #(
    parameter  int unsigned N_WAY = 8,
    localparam int unsigned WAY_W = $clog2(N_WAY)
) (
    input  logic [N_WAY-2:0] plru_i,
    input  logic [WAY_W-1:0] touch_way_i,
    output logic [WAY_W-1:0] victim_way_o,
    output logic [N_WAY-2:0] plru_o
);

    localparam int unsigned Nodes = 2 * N_WAY - 1;

    logic [Nodes-1:0] path;
    logic [Nodes-1:0] anc;

    // Leaves sit at heap positions N_WAY-1 .. 2*N_WAY-2.
    always_comb begin
        path    = '0;
        path[0] = 1'b1;
        for (int n = 0; n < int'(N_WAY) - 1; n++) begin
            path[2*n+1] = path[n] & ~plru_i[n];
            path[2*n+2] = path[n] &  plru_i[n];
        end
        victim_way_o = '0;
        for (int w = 0; w < int'(N_WAY); w++) begin
            if (path[int'(N_WAY)-1+w]) victim_way_o = WAY_W'(w);
        end
    end

    // Nodes on the touched path point to the sibling subtree.
    always_comb begin
        anc    = '0;
        plru_o = plru_i;
        for (int w = 0; w < int'(N_WAY); w++) begin
            anc[int'(N_WAY)-1+w] = (touch_way_i == WAY_W'(w));
        end
        for (int n = int'(N_WAY) - 2; n >= 0; n--) begin
            anc[n]    = anc[2*n+1] | anc[2*n+2];
            plru_o[n] = anc[n] ? anc[2*n+1] : plru_i[n];
        end
    end

endmodule

// File: rtl/llc_tag_ctrl.sv
// N-way set-associative LLC tag/MESI controller with init sweep, tree-PLRU and writeback report.
module llc_tag_ctrl
    import pkg_llc::*;
#(
    parameter int unsigned ADDR_SIZE  = DefAddrSize,
    parameter int unsigned N_WAY      = DefNWay,
    parameter int unsigned NUM_SETS   = DefNumSets,
    parameter int unsigned LINE_BYTES = DefLineBytes
) (
    input logic          clk,
    input logic          rst,
    llc_tag_ctrl_if.slave bus
);

    localparam int unsigned OFFSET_SIZE = $clog2(LINE_BYTES);
    localparam int unsigned INDEX_SIZE  = $clog2(NUM_SETS);
    localparam int unsigned TAG_SIZE    = ADDR_SIZE - INDEX_SIZE - OFFSET_SIZE;
    localparam int unsigned WAY_W       = $clog2(N_WAY);

    typedef struct packed {
        logic                valid;
        logic                dirty;
        logic [TAG_SIZE-1:0] tag;
        mesi_e               mesi;
    } way_st;

    typedef struct packed {
        logic [N_WAY-2:0]        plru_bits;
        way_st [N_WAY-1:0]       ways;
    } set_st;

    set_st                 mem_q [NUM_SETS];
    llc_state_e            state_q, state_d;
    logic [INDEX_SIZE-1:0] init_cnt_q;
    logic                  init_done_q;
    logic                  init_last;

    req_op_e               req_op_q;
    logic [TAG_SIZE-1:0]   req_tag_q;
    logic [INDEX_SIZE-1:0] req_idx_q;
    logic                  req_shared_q;
    set_st                 set_q, set_d;
    logic                  accept;

    logic                  hit, free_any;
    logic [WAY_W-1:0]      hit_way, free_way, alloc_way, touch_way, plru_victim;
    logic [N_WAY-2:0]      plru_next;
    mesi_e                 new_mesi;

    logic                  rsp_hit_q, rsp_hit_d, rsp_wb_q, rsp_wb_d;
    logic [WAY_W-1:0]      rsp_way_q, rsp_way_d;
    mesi_e                 rsp_mesi_q, rsp_mesi_d;
    logic [ADDR_SIZE-1:0]  rsp_wb_addr_q, rsp_wb_addr_d;

    // Byte offset within the line never affects tag state.
    logic                  unused_offset;
    assign unused_offset = ^bus.req_addr[OFFSET_SIZE-1:0];

    assign init_last = (init_cnt_q == INDEX_SIZE'(NUM_SETS - 1));
    assign accept    = (state_q == StIdle) && bus.req_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StInit;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StInit:   if (init_last) state_d = StIdle;
            StIdle:   if (bus.req_valid) state_d = StLookup;
            StLookup: state_d = StResp;
            StResp:   if (bus.rsp_ready) state_d = StIdle;
            default:  state_d = StInit;
        endcase
    end

    always_comb begin
        bus.req_ready   = (state_q == StIdle);
        bus.rsp_valid   = (state_q == StResp);
        bus.rsp_hit     = rsp_hit_q;
        bus.rsp_way     = rsp_way_q;
        bus.rsp_mesi    = rsp_mesi_q;
        bus.rsp_wb      = rsp_wb_q;
        bus.rsp_wb_addr = rsp_wb_addr_q;
        bus.init_done   = init_done_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init_cnt_q    <= '0;
            init_done_q   <= 1'b0;
            req_op_q      <= OpRead;
            req_tag_q     <= '0;
            req_idx_q     <= '0;
            req_shared_q  <= 1'b0;
            set_q         <= '0;
            rsp_hit_q     <= 1'b0;
            rsp_way_q     <= '0;
            rsp_mesi_q    <= MesiI;
            rsp_wb_q      <= 1'b0;
            rsp_wb_addr_q <= '0;
        end else begin
            if (state_q == StInit) begin
                init_cnt_q <= init_cnt_q + 1'b1;
                if (init_last) init_done_q <= 1'b1;
            end
            if (accept) begin
                req_op_q     <= req_op_e'(bus.req_op);
                req_tag_q    <= bus.req_addr[ADDR_SIZE-1 -: TAG_SIZE];
                req_idx_q    <= bus.req_addr[OFFSET_SIZE +: INDEX_SIZE];
                req_shared_q <= bus.req_shared;
                set_q        <= mem_q[bus.req_addr[OFFSET_SIZE +: INDEX_SIZE]];
            end
            if (state_q == StLookup) begin
                rsp_hit_q     <= rsp_hit_d;
                rsp_way_q     <= rsp_way_d;
                rsp_mesi_q    <= rsp_mesi_d;
                rsp_wb_q      <= rsp_wb_d;
                rsp_wb_addr_q <= rsp_wb_addr_d;
            end
        end
    end

    // Tag array is deliberately not reset; the INIT sweep clears it.
    always_ff @(posedge clk) begin
        if (state_q == StInit)        mem_q[init_cnt_q] <= '0;
        else if (state_q == StLookup) mem_q[req_idx_q]  <= set_d;
    end

    always_comb begin
        hit      = 1'b0;
        hit_way  = '0;
        free_any = 1'b0;
        free_way = '0;
        for (int w = int'(N_WAY) - 1; w >= 0; w--) begin
            if (set_q.ways[w].mesi != MesiI && set_q.ways[w].tag == req_tag_q) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!set_q.ways[w].valid) begin
                free_any = 1'b1;
                free_way = WAY_W'(w);
            end
        end
        alloc_way = free_any ? free_way : plru_victim;
        touch_way = hit ? hit_way : alloc_way;
    end

    llc_plru_tree #(
        .N_WAY (N_WAY)
    ) u_plru (
        .plru_i       (set_q.plru_bits),
        .touch_way_i  (touch_way),
        .victim_way_o (plru_victim),
        .plru_o       (plru_next)
    );

    always_comb begin
        set_d         = set_q;
        new_mesi      = MesiI;
        rsp_hit_d     = 1'b0;
        rsp_way_d     = '0;
        rsp_mesi_d    = MesiI;
        rsp_wb_d      = 1'b0;
        rsp_wb_addr_d = '0;
        unique case (req_op_q)
            OpRead, OpWrite: begin
                rsp_hit_d = hit;
                rsp_way_d = touch_way;
                if (hit) begin
                    new_mesi = (req_op_q == OpWrite) ? MesiM : set_q.ways[hit_way].mesi;
                    set_d.ways[hit_way].mesi  = new_mesi;
                    set_d.ways[hit_way].dirty = is_dirty(new_mesi);
                end else begin
                    new_mesi = (req_op_q == OpWrite) ? MesiM : (req_shared_q ? MesiS : MesiE);
                    set_d.ways[alloc_way] = '{valid: 1'b1, dirty: is_dirty(new_mesi),
                                              tag: req_tag_q, mesi: new_mesi};
                    if (set_q.ways[alloc_way].dirty) begin
                        rsp_wb_d      = 1'b1;
                        rsp_wb_addr_d = {set_q.ways[alloc_way].tag, req_idx_q,
                                         {OFFSET_SIZE{1'b0}}};
                    end
                end
                rsp_mesi_d      = new_mesi;
                set_d.plru_bits = plru_next;
            end
            OpSnoopRd, OpSnoopInv: begin
                if (hit) begin
                    new_mesi = (req_op_q == OpSnoopRd) ? MesiS : MesiI;
                    set_d.ways[hit_way].valid = (new_mesi != MesiI);
                    set_d.ways[hit_way].dirty = 1'b0;
                    set_d.ways[hit_way].mesi  = new_mesi;
                    rsp_hit_d  = 1'b1;
                    rsp_way_d  = hit_way;
                    rsp_mesi_d = new_mesi;
                    if (set_q.ways[hit_way].dirty) begin
                        rsp_wb_d      = 1'b1;
                        rsp_wb_addr_d = {req_tag_q, req_idx_q, {OFFSET_SIZE{1'b0}}};
                    end
                end
            end
            default: ;
        endcase
    end

endmodule
